// File: rtl/ara_perf_snapshot_regs.sv
// APB register bank holding a coherent snapshot of the Ara perf counters.
// Counters are captured on update_i; software reads each 64-bit value as
// LO then HI, with HI served from a latch so the pair is always consistent.
module ara_perf_snapshot_regs #(
    parameter int unsigned NrCnt     = 4,
    parameter int unsigned AddrWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   update_i,
    input  logic [NrCnt*64-1:0]    cnt_i,
    output logic                   hw_cnt_en_o,
    output logic                   snap_valid_o,
    input  logic [AddrWidth-1:0]   paddr_i,
    input  logic                   psel_i,
    input  logic                   penable_i,
    input  logic                   pwrite_i,
    input  logic [31:0]            pwdata_i,
    output logic [31:0]            prdata_o,
    output logic                   pready_o,
    output logic                   pslverr_o
);

    // The bank is sized for the largest legal NrCnt so the read mux can be
    // indexed with a plain 3-bit index; unused slots stay at zero.
    localparam int unsigned MaxCnt = 8;
    localparam logic [5:0]  NrCntW = 6'(NrCnt);

    typedef enum logic {
        IDLE,
        RESP
    } state_e;

    state_e        state_q;
    logic [31:0]   prdata_q;
    logic          pslverr_q;

    logic          cnt_en_q;
    logic [63:0]   snap_q [MaxCnt];
    logic [31:0]   hi_latch_q;
    logic          hi_pending_q;
    logic [2:0]    latch_idx_q;
    logic          valid_q;
    logic          overrun_q;
    logic [15:0]   snap_cnt_q;

    logic [MaxCnt*64-1:0] cnt_pad;
    logic          acc;
    logic [7:0]    off;
    logic [4:0]    idx;
    logic          idx_ok;
    logic [31:0]   rd_data;
    logic          err;
    logic          ctrl_wr;
    logic          lo_rd;
    logic          hi_rd;
    logic          clear;
    logic          capture;

    // Address bits above the decoded byte and unused write-data bits.
    logic unused_in;
    assign unused_in = ^{paddr_i[AddrWidth-1:8], pwdata_i[31:2]};

    assign cnt_pad = (MaxCnt*64)'(cnt_i);

    // Decode the access presented in IDLE; side-effect strobes only fire on a
    // legal access so an erroring access changes nothing.
    always_comb begin
        acc     = (state_q == IDLE) && psel_i && penable_i;
        off     = paddr_i[7:0];
        idx     = off[7:3] - 5'd1;
        idx_ok  = ({1'b0, idx} < NrCntW);
        rd_data = '0;
        err     = 1'b0;
        ctrl_wr = 1'b0;
        lo_rd   = 1'b0;
        hi_rd   = 1'b0;
        if (off[1:0] != 2'b00) begin
            err = 1'b1;
        end else if (off == 8'h00) begin
            if (pwrite_i) ctrl_wr = 1'b1;
            else          rd_data = {31'b0, cnt_en_q};
        end else if (off == 8'h04) begin
            if (pwrite_i) err = 1'b1;
            else          rd_data = {snap_cnt_q, 14'b0, overrun_q, valid_q};
        end else begin
            if (pwrite_i || !idx_ok) begin
                err = 1'b1;
            end else if (!off[2]) begin
                lo_rd   = 1'b1;
                rd_data = snap_q[idx[2:0]][31:0];
            end else begin
                hi_rd   = 1'b1;
                rd_data = (hi_pending_q && (latch_idx_q == idx[2:0])) ?
                          hi_latch_q : snap_q[idx[2:0]][63:32];
            end
        end
        if (!acc) begin
            ctrl_wr = 1'b0;
            lo_rd   = 1'b0;
            hi_rd   = 1'b0;
        end
        clear   = ctrl_wr && pwdata_i[1];
        capture = update_i && !clear;
    end

    // APB handshake: register the response in the decode cycle, present it
    // for exactly one cycle in RESP.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (acc) begin
                        state_q   <= RESP;
                        prdata_q  <= err ? 32'h0 : rd_data;
                        pslverr_q <= err;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Snapshot bank, coherent-read latch and status; reads use the values
    // from before any same-cycle capture, and clear overrides capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_en_q     <= 1'b0;
            hi_latch_q   <= '0;
            hi_pending_q <= 1'b0;
            latch_idx_q  <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            snap_cnt_q   <= '0;
            for (int i = 0; i < MaxCnt; i++) snap_q[i] <= '0;
        end else begin
            if (ctrl_wr) cnt_en_q <= pwdata_i[0];
            if (clear) begin
                valid_q      <= 1'b0;
                overrun_q    <= 1'b0;
                snap_cnt_q   <= '0;
                hi_pending_q <= 1'b0;
                for (int i = 0; i < MaxCnt; i++) snap_q[i] <= '0;
            end else begin
                if (lo_rd) begin
                    hi_latch_q   <= snap_q[idx[2:0]][63:32];
                    latch_idx_q  <= idx[2:0];
                    hi_pending_q <= 1'b1;
                end else if (hi_rd) begin
                    hi_pending_q <= 1'b0;
                end
                if (capture) begin
                    for (int i = 0; i < MaxCnt; i++) snap_q[i] <= cnt_pad[64*i +: 64];
                    valid_q    <= 1'b1;
                    snap_cnt_q <= snap_cnt_q + 16'd1;
                    if (hi_pending_q) overrun_q <= 1'b1;
                end
            end
        end
    end

    assign pready_o     = (state_q == RESP);
    assign prdata_o     = pready_o ? prdata_q : 32'h0;
    assign pslverr_o    = pready_o & pslverr_q;
    assign hw_cnt_en_o  = cnt_en_q;
    assign snap_valid_o = valid_q;

endmodule
